// File: rtl/iob_pbus_arbiter.sv
// Two-requester round-robin arbiter onto a single IOb manager port.
// Requests are forwarded combinationally; the winner is locked until completion.
module iob_pbus_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                cke_i,
   input  logic                r0_iob_valid_i,
   input  logic [ADDR_W-1:0]   r0_iob_addr_i,
   input  logic [DATA_W-1:0]   r0_iob_wdata_i,
   input  logic [DATA_W/8-1:0] r0_iob_wstrb_i,
   output logic                r0_iob_rvalid_o,
   output logic [DATA_W-1:0]   r0_iob_rdata_o,
   output logic                r0_iob_ready_o,
   input  logic                r1_iob_valid_i,
   input  logic [ADDR_W-1:0]   r1_iob_addr_i,
   input  logic [DATA_W-1:0]   r1_iob_wdata_i,
   input  logic [DATA_W/8-1:0] r1_iob_wstrb_i,
   output logic                r1_iob_rvalid_o,
   output logic [DATA_W-1:0]   r1_iob_rdata_o,
   output logic                r1_iob_ready_o,
   output logic                m_iob_valid_o,
   output logic [ADDR_W-1:0]   m_iob_addr_o,
   output logic [DATA_W-1:0]   m_iob_wdata_o,
   output logic [DATA_W/8-1:0] m_iob_wstrb_o,
   input  logic                m_iob_rvalid_i,
   input  logic [DATA_W-1:0]   m_iob_rdata_i,
   input  logic                m_iob_ready_i
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_READY  = 2'd1,
      WAIT_RVALID = 2'd2
   } state_t;

   state_t state;
   logic   gnt;
   logic   last;

   logic                any_req;
   logic                winner;
   logic                sel;
   logic                owned;
   logic                busy_rv;
   logic                s_valid;
   logic [ADDR_W-1:0]   s_addr;
   logic [DATA_W-1:0]   s_wdata;
   logic [DATA_W/8-1:0] s_wstrb;
   logic                s_write;
   logic                rdy;
   logic                rv;

   always_comb begin
      any_req = r0_iob_valid_i | r1_iob_valid_i;
      unique case ({r1_iob_valid_i, r0_iob_valid_i})
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last;
         default: winner = gnt;
      endcase
      sel     = (state == IDLE) ? winner : gnt;
      // An idle bus with no request has no owner, so nothing is forwarded.
      owned   = (state == IDLE) ? any_req : 1'b1;
      busy_rv = (state == WAIT_RVALID);
      s_valid = sel ? r1_iob_valid_i : r0_iob_valid_i;
      s_addr  = sel ? r1_iob_addr_i  : r0_iob_addr_i;
      s_wdata = sel ? r1_iob_wdata_i : r0_iob_wdata_i;
      s_wstrb = sel ? r1_iob_wstrb_i : r0_iob_wstrb_i;
      s_write = |s_wstrb;

      m_iob_valid_o = arst_n_i & s_valid & ~busy_rv;
      m_iob_addr_o  = (arst_n_i & owned) ? s_addr  : '0;
      m_iob_wdata_o = (arst_n_i & owned) ? s_wdata : '0;
      m_iob_wstrb_o = (arst_n_i & owned) ? s_wstrb : '0;

      rdy = arst_n_i & owned & m_iob_ready_i & ~busy_rv;
      rv  = arst_n_i & owned & m_iob_rvalid_i;
      r0_iob_ready_o  = rdy & ~sel;
      r1_iob_ready_o  = rdy & sel;
      r0_iob_rvalid_o = rv & ~sel;
      r1_iob_rvalid_o = rv & sel;
      r0_iob_rdata_o  = m_iob_rdata_i;
      r1_iob_rdata_o  = m_iob_rdata_i;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
      end else if (cke_i) begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  gnt <= winner;
                  if (!m_iob_ready_i) begin
                     state <= WAIT_READY;
                  end else if (!s_write && !m_iob_rvalid_i) begin
                     state <= WAIT_RVALID;
                  end else begin
                     last <= winner;
                  end
               end
            end
            WAIT_READY: begin
               if (m_iob_ready_i) begin
                  if (s_write || m_iob_rvalid_i) begin
                     state <= IDLE;
                     last  <= gnt;
                  end else begin
                     state <= WAIT_RVALID;
                  end
               end
            end
            WAIT_RVALID: begin
               if (m_iob_rvalid_i) begin
                  state <= IDLE;
                  last  <= gnt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
